step_enable_gen: RTL
====================

// Module: step_enable_gen
// PURPOSE
//  Generates the Core clock-enable for the board-level workbench, replacing the inline btnU debounce logic.
//  Run mode: free-running, divided enable. Step mode: exactly one Core cycle per debounced button press.
//  Sits upstream of Core: feeds core_ce. Also counts executed steps for the LEDs.
//  Accepts a halt request back from Core.
// PARAMETERS
//  DEBOUNCE_CYCLES  50_000_000  consecutive equal samples needed to change debounced level (>=1)
//  RUN_DIV          1           run-mode divider; one core_ce pulse every RUN_DIV clk cycles (>=1)
// PORTS
//  clk         in   1   system clock; single clock domain
//  rst         in   1   synchronous, active-high reset
//  btn_raw     in   1   raw asynchronous push-button (btnU), bouncing
//  run_en      in   1   level, 1 = free-run mode, 0 = single-step mode (switch)
//  halt_req    in   1   level from Core, 1 = stop issuing enables
//  core_ce     out  1   registered clock-enable to Core, one-cycle pulses
//  running     out  1   1 while in S_RUN
//  halted      out  1   1 while in S_HALT
//  step_count  out  32  number of core_ce pulses issued since reset
// BEHAVIOUR
//  Reset: state=S_STEP; core_ce=0, running=0, halted=0, step_count=0; sync FFs=0, btn_db=0, counters=0.
//  Synchroniser: 2-FF chain, btn_raw -> btn_s.
//  Debounce:
//   - cnt clears whenever btn_s==btn_db; otherwise cnt increments.
//   - When cnt reaches DEBOUNCE_CYCLES-1 with btn_s!=btn_db: btn_db<=btn_s, cnt<=0.
//   - cnt width = $clog2(DEBOUNCE_CYCLES+1); cnt never wraps.
//   - press = btn_db rising edge, 1-cycle internal strobe.
//  Latency: btn_raw held 1 from edge E0 -> core_ce high in cycle E0+DEBOUNCE_CYCLES+3, high for exactly 1 cycle.
//  FSM, priority per cycle: rst > halt_req > run_en > press.
//   S_STEP:
//    - halt_req -> S_HALT.
//    - else run_en -> S_RUN; divider cleared; no step pulse.
//    - else press -> core_ce=1 next cycle, go S_WAIT_REL.
//   S_WAIT_REL:
//    - core_ce=0; btn_db==0 -> S_STEP.
//    - halt_req -> S_HALT; run_en -> S_RUN.
//    - Presses are ignored while in this state.
//   S_RUN:
//    - div counts 0..RUN_DIV-1 and wraps.
//    - core_ce=1 in the cycle after div==RUN_DIV-1, so the first pulse comes RUN_DIV cycles after entry.
//    - RUN_DIV=1 -> core_ce=1 every cycle from the cycle after entry.
//    - halt_req -> S_HALT.
//    - run_en==0 -> S_WAIT_REL, so a held button does not single-step; div cleared.
//   S_HALT:
//    - core_ce=0, halted=1; presses ignored.
//    - Exits to S_WAIT_REL only when halt_req==0 && run_en==0.
//  core_ce is forced 0 in the cycle halt_req is first seen; no pulse is ever issued while halt_req==1.
//  step_count increments by 1 in the same cycle core_ce is registered high; wraps 0xFFFF_FFFF -> 0.
//  running=(state==S_RUN) and halted=(state==S_HALT), both registered with the state.
//  Reset mid-pulse or mid-run: the next cycle satisfies all reset values; a held button needs release + re-press.
// TESTING  (bench: DEBOUNCE_CYCLES=4, RUN_DIV=3)
//  1 rst 3 cycles, any inputs -> core_ce=0, running=0, halted=0, step_count=0.
//  2 btn_raw=1 held 20 cycles from E0 -> single core_ce pulse at E0+7, step_count=1;
//    release 10 cycles, press again -> step_count=2.
//  3 btn_raw toggling every 2 cycles for 40 cycles, then 0 -> core_ce never 1, step_count=0.
//  4 run_en=1 for 30 cycles -> 10 core_ce pulses spaced 3 cycles, running=1;
//    run_en=0 -> no further pulses, running=0 next cycle.
//  5 halt_req=1 during RUN -> core_ce 0 from that cycle, halted=1, presses ignored;
//    halt_req=0 & run_en=0 -> S_WAIT_REL, halted=0.
//  6 halt_req and press strobe in the same cycle -> no pulse, S_HALT;
//    preload step_count=0xFFFF_FFFF via run -> next pulse gives 0.

Source files
------------

// File: rtl/step_enable_gen.sv
// Core clock-enable generator: free-running divided enable (run mode) or one
// enable per debounced button press (step mode), with halt handshake and step counter.
module step_enable_gen #(
    parameter int DEBOUNCE_CYCLES = 50_000_000,
    parameter int RUN_DIV         = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_raw,
    input  logic        run_en,
    input  logic        halt_req,
    output logic        core_ce,
    output logic        running,
    output logic        halted,
    output logic [31:0] step_count
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_STEP,
        S_WAIT_REL,
        S_RUN,
        S_HALT
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_sync_vld;
    logic             r_armed;
    logic             r_btn_db;
    logic             r_btn_db_q;
    logic [CNT_W-1:0] r_db_cnt;
    logic             w_press;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_ce_nxt;
    logic             r_core_ce;
    logic             r_running;
    logic             r_halted;
    logic [31:0]      r_step_count;

    // r_armed stays low until the synchronised button has been seen released
    // after reset, so a button held through reset cannot trigger a step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync_vld <= 2'b00;
            r_armed    <= 1'b0;
            r_btn_db   <= 1'b0;
            r_btn_db_q <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync1    <= btn_raw;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_btn_db_q <= r_btn_db;
            if (r_sync_vld[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
            if (r_sync2 == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == CNT_LAST) begin
                r_btn_db <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + CNT_W'(1);
            end
        end
    end

    assign w_press = r_btn_db & ~r_btn_db_q & r_armed;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_ce_nxt    = 1'b0;
        unique case (r_state)
            S_STEP: begin
                if (halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (run_en) begin
                    w_state_nxt = S_RUN;
                    w_div_nxt   = '0;
                end else if (w_press) begin
                    w_ce_nxt    = 1'b1;
                    w_state_nxt = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (run_en) begin
                    w_state_nxt = S_RUN;
                    w_div_nxt   = '0;
                end else if (!r_btn_db) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (!run_en) begin
                    w_state_nxt = S_WAIT_REL;
                    w_div_nxt   = '0;
                end else if (r_div == DIV_LAST) begin
                    w_ce_nxt  = 1'b1;
                    w_div_nxt = '0;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_HALT: begin
                if (!halt_req && !run_en) begin
                    w_state_nxt = S_WAIT_REL;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_STEP;
            r_div        <= '0;
            r_core_ce    <= 1'b0;
            r_running    <= 1'b0;
            r_halted     <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_div        <= w_div_nxt;
            r_core_ce    <= w_ce_nxt;
            r_running    <= (w_state_nxt == S_RUN);
            r_halted     <= (w_state_nxt == S_HALT);
            r_step_count <= r_step_count + 32'(w_ce_nxt);
        end
    end

    assign core_ce    = r_core_ce;
    assign running    = r_running;
    assign halted     = r_halted;
    assign step_count = r_step_count;

endmodule
